// File: rtl/switch_debounce_if.sv
// Signal bundle between the switch pads and the debouncer.
// fall_pulse is present only when SWITCH_DEBOUNCE_EDGE_EN is defined.
interface switch_debounce_if;
    logic       nFork_raw;
    logic       nCrank_raw;
    logic       nMode_raw;
    logic       nTrip_raw;
    logic       nFork;
    logic       nCrank;
    logic       nMode;
    logic       nTrip;
    logic [3:0] pending;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [3:0] fall_pulse;

    modport master (
        output nFork_raw, nCrank_raw, nMode_raw, nTrip_raw,
        input  nFork, nCrank, nMode, nTrip, pending, fall_pulse
    );
    modport slave (
        input  nFork_raw, nCrank_raw, nMode_raw, nTrip_raw,
        output nFork, nCrank, nMode, nTrip, pending, fall_pulse
    );
`else
    modport master (
        output nFork_raw, nCrank_raw, nMode_raw, nTrip_raw,
        input  nFork, nCrank, nMode, nTrip, pending
    );
    modport slave (
        input  nFork_raw, nCrank_raw, nMode_raw, nTrip_raw,
        output nFork, nCrank, nMode, nTrip, pending
    );
`endif
endinterface

// File: rtl/switch_debounce.sv
// Four-channel switch debouncer: 2-flop synchronizer, per-channel counter and STABLE/PENDING FSM.
// Define SWITCH_DEBOUNCE_EDGE_EN to add the registered one-cycle fall_pulse output.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500
) (
    input  logic              HCLK,
    input  logic              HRESET,
    switch_debounce_if.slave  sw
);
    typedef enum logic {ST_STABLE = 1'b0, ST_PENDING = 1'b1} state_t;

    localparam logic [15:0] LAST_CNT = 16'(DEBOUNCE_CYCLES - 1);

    logic [3:0] raw;
    logic [3:0] s1_q;
    logic [3:0] s2_q;
    logic [3:0] out_vec;
    logic [3:0] pend_vec;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [3:0] out_d_vec;
    logic [3:0] fall_q;
`endif

    // Bit order Fork, Crank, Mode, Trip is used for every vector.
    assign raw = {sw.nTrip_raw, sw.nMode_raw, sw.nCrank_raw, sw.nFork_raw};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1_q <= 4'hF;
            s2_q <= 4'hF;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            state_t      state_q, state_d;
            logic [15:0] cnt_q, cnt_d;
            logic        out_q, out_d;

            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    state_q <= ST_STABLE;
                    cnt_q   <= 16'd0;
                    out_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    out_q   <= out_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                out_d   = out_q;
                case (state_q)
                    ST_STABLE: begin
                        cnt_d = 16'd0;
                        if (s2_q[gi] != out_q) begin
                            // A single-cycle debounce accepts the new level straight away.
                            if (DEBOUNCE_CYCLES == 1) begin
                                out_d = s2_q[gi];
                            end else begin
                                state_d = ST_PENDING;
                                cnt_d   = 16'd1;
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (s2_q[gi] == out_q) begin
                            state_d = ST_STABLE;
                            cnt_d   = 16'd0;
                        end else if (cnt_q == LAST_CNT) begin
                            out_d   = s2_q[gi];
                            state_d = ST_STABLE;
                            cnt_d   = 16'd0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                endcase
            end

            assign out_vec[gi]  = out_q;
            assign pend_vec[gi] = (state_q == ST_PENDING);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            assign out_d_vec[gi] = out_d;
`endif
        end
    endgenerate

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    // Registered alongside the outputs so the pulse coincides with the first low cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            fall_q <= 4'h0;
        end else begin
            fall_q <= out_vec & ~out_d_vec;
        end
    end

    assign sw.fall_pulse = fall_q;
`endif

    assign sw.nFork   = out_vec[0];
    assign sw.nCrank  = out_vec[1];
    assign sw.nMode   = out_vec[2];
    assign sw.nTrip   = out_vec[3];
    assign sw.pending = pend_vec;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce (DEBOUNCE_CYCLES=4): directed scenarios plus randomized bouncing
// checked every cycle against a history-window model of the debounce rule.
module tb_switch_debounce;
    localparam int N = 4;

    logic HCLK;
    logic HRESET;
    int   n_cmp = 0;
    int   n_bad = 0;

    switch_debounce_if bus ();

    switch_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .sw     (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    logic [3:0] outs;
    logic [3:0] raws;
    assign outs = {bus.nTrip, bus.nMode, bus.nCrank, bus.nFork};
    assign raws = {bus.nTrip_raw, bus.nMode_raw, bus.nCrank_raw, bus.nFork_raw};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic set_raw(input logic [3:0] v);
        bus.nFork_raw  = v[0];
        bus.nCrank_raw = v[1];
        bus.nMode_raw  = v[2];
        bus.nTrip_raw  = v[3];
    endtask

    task automatic step();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    // Model: the output flips to v once the last N synchronized samples all equal v
    // (sample seen by the logic at edge t is the raw value taken two edges earlier).
    logic [3:0] hist[$];
    logic [3:0] m_out  = 4'hF;
    logic [3:0] m_pend = 4'h0;
    logic [3:0] m_fall = 4'h0;

    initial begin
        logic       rst_s;
        logic [3:0] raw_s;
        logic [3:0] prev;
        logic       v;
        logic       all_v;
        forever begin
            @(posedge HCLK);
            rst_s = HRESET;
            raw_s = raws;
            if (rst_s) begin
                hist.delete();
                for (int k = 0; k < N + 2; k++) hist.push_back(4'hF);
                m_out  = 4'hF;
                m_pend = 4'h0;
                m_fall = 4'h0;
            end else begin
                hist.push_front(raw_s);
                void'(hist.pop_back());
                prev = m_out;
                for (int c = 0; c < 4; c++) begin
                    v     = ~prev[c];
                    all_v = 1'b1;
                    for (int k = 2; k <= N + 1; k++)
                        if (hist[k][c] != v) all_v = 1'b0;
                    if (all_v) m_out[c] = v;
                end
                m_fall = prev & ~m_out;
                for (int c = 0; c < 4; c++) m_pend[c] = (hist[2][c] != m_out[c]);
            end
            #1;
            chk("mon_outs", {4'h0, outs}, {4'h0, m_out});
            chk("mon_pending", {4'h0, bus.pending}, {4'h0, m_pend});
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            chk("mon_fall_pulse", {4'h0, bus.fall_pulse}, {4'h0, m_fall});
`endif
        end
    end

    initial begin
        logic [3:0] r;
        int         p;
        HRESET = 1'b1;
        set_raw(4'h0);
        #1;
        chk("reset_outs", {4'h0, outs}, 8'h0F);
        chk("reset_pending", {4'h0, bus.pending}, 8'h00);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        chk("reset_fall", {4'h0, bus.fall_pulse}, 8'h00);
`endif
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3) chk("release_pending", {4'h0, bus.pending}, 8'h0F);
            if (k == 5) chk("release_outs_e5", {4'h0, outs}, 8'h0F);
            if (k == 6) chk("release_outs_e6", {4'h0, outs}, 8'h00);
        end

        set_raw(4'hF);
        repeat (8) step();
        chk("all_released", {4'h0, outs}, 8'h0F);

        // Fork press: pending for edges 3..5, output falls on edge 6.
        set_raw(4'b1110);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("fork_pend_e%0d", k), {7'h0, bus.pending[0]}, {7'h0, (k >= 3 && k <= 5)});
            chk($sformatf("fork_out_e%0d", k), {7'h0, bus.nFork}, {7'h0, (k < 6)});
        end

        // Crank glitch of 3 cycles is rejected.
        set_raw(4'b1100);
        repeat (3) step();
        set_raw(4'b1110);
        repeat (8) begin
            step();
            chk("crank_glitch_out", {7'h0, bus.nCrank}, 8'h01);
        end
        chk("crank_glitch_pend", {7'h0, bus.pending[1]}, 8'h00);

        // Mode release bounce: only the final held rise counts.
        set_raw(4'b1010);
        repeat (8) step();
        chk("mode_low", {7'h0, bus.nMode}, 8'h00);
        set_raw(4'b1110);
        repeat (2) step();
        set_raw(4'b1010);
        step();
        set_raw(4'b1110);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) chk("mode_rise_e5", {7'h0, bus.nMode}, 8'h00);
            if (k == 6) chk("mode_rise_e6", {7'h0, bus.nMode}, 8'h01);
        end

        // Trip: reset while pending discards the count.
        set_raw(4'hF);
        repeat (8) step();
        set_raw(4'b0111);
        repeat (4) step();
        chk("trip_pending", {7'h0, bus.pending[3]}, 8'h01);
        HRESET = 1'b1;
        #1;
        chk("trip_rst_out", {7'h0, bus.nTrip}, 8'h01);
        chk("trip_rst_pending", {4'h0, bus.pending}, 8'h00);
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) chk("trip_after_rst_e5", {7'h0, bus.nTrip}, 8'h01);
            if (k == 6) chk("trip_after_rst_e6", {7'h0, bus.nTrip}, 8'h00);
        end

        // Fork and Trip pressed together.
        set_raw(4'hF);
        repeat (8) step();
        set_raw(4'b0110);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) chk("dual_press_outs", {4'h0, outs}, 8'h06);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            if (k == 6) chk("dual_fall_pulse", {4'h0, bus.fall_pulse}, 8'h09);
            if (k == 7) chk("dual_fall_clear", {4'h0, bus.fall_pulse}, 8'h00);
`endif
        end

        // Randomized bouncing with occasional resets; the monitor checks every cycle.
        r = 4'hF;
        set_raw(r);
        p = 6;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) p = int'($urandom_range(12, 2));
            for (int c = 0; c < 4; c++)
                if ($urandom_range(p - 1, 0) == 0) r[c] = ~r[c];
            set_raw(r);
            if ($urandom_range(399, 0) == 0) begin
                HRESET = 1'b1;
                repeat (2) step();
                HRESET = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
